// File: rtl/writeback_stage.sv
// ---------------------------------------------------------------------------
// writeback_stage
//
// Merges two result streams onto the single register-file write port.
// ALU results go straight to the write register. Load results are buffered
// in a 4-entry FIFO and drain in cycles the ALU does not claim the port.
// A 3-bit starvation counter forces one load through after seven
// consecutive ALU wins while loads are waiting.
//
// Optional feature: define WB_FORWARD_EN to compile in the write bypass on
// the two read buses. Without it the read data passes straight through.
//
// Ports
//   clk, reset                     rising-edge clock, synchronous active-high reset
//   alu_valid/alu_ready            ALU result handshake
//   alu_addr, alu_data             ALU destination register and value
//   mem_valid/mem_ready            load result handshake
//   mem_addr, mem_data             load destination register and value
//   write, wrAddr, wrData          registered register-file write port
//   rdAddrA/B, rfDataA/B           register-file read addresses and raw data
//   rdDataA/B                      read data seen by the pipeline
//   fifo_count                     number of buffered load results, 0..4
// ---------------------------------------------------------------------------
module writeback_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        alu_valid,
  output logic        alu_ready,
  input  logic [4:0]  alu_addr,
  input  logic [63:0] alu_data,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [4:0]  mem_addr,
  input  logic [63:0] mem_data,
  output logic        write,
  output logic [4:0]  wrAddr,
  output logic [63:0] wrData,
  input  logic [4:0]  rdAddrA,
  input  logic [4:0]  rdAddrB,
  input  logic [63:0] rfDataA,
  input  logic [63:0] rfDataB,
  output logic [63:0] rdDataA,
  output logic [63:0] rdDataB,
  output logic [2:0]  fifo_count
);

  localparam logic [2:0] FIFO_DEPTH = 3'd4;

  // Load FIFO storage and control
  logic [4:0]  fifo_addr_q [4];
  logic [63:0] fifo_data_q [4];
  logic [1:0]  wr_ptr_q, wr_ptr_d;
  logic [1:0]  rd_ptr_q, rd_ptr_d;
  logic [2:0]  count_q,  count_d;
  logic [2:0]  starv_q,  starv_d;

  // Registered write port
  logic        write_q,    write_d;
  logic [4:0]  wr_addr_q,  wr_addr_d;
  logic [63:0] wr_data_q,  wr_data_d;

  logic alu_win;
  logic push;
  logic pop;

  // The ALU is held off for one cycle once it has starved waiting loads
  // for seven straight wins; that cycle is handed to the FIFO head.
  assign alu_ready = !((starv_q == 3'd7) && (count_q != 3'd0));
  assign mem_ready = (count_q != FIFO_DEPTH);

  assign alu_win = alu_valid && alu_ready;
  assign push    = mem_valid && mem_ready;
  // count_q only counts entries pushed in earlier cycles, so a fresh push
  // can never be popped in the cycle it arrives.
  assign pop     = !alu_win && (count_q != 3'd0);

  // NOTE: every always_comb output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    starv_d   = starv_q;
    write_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;

    if (push) wr_ptr_d = wr_ptr_q + 2'd1;
    if (pop)  rd_ptr_d = rd_ptr_q + 2'd1;

    unique case ({push, pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase

    if (pop || (count_q == 3'd0)) begin
      starv_d = 3'd0;
    end else if (alu_win) begin
      starv_d = starv_q + 3'd1;
    end

    if (alu_win) begin
      write_d   = 1'b1;
      wr_addr_d = alu_addr;
      wr_data_d = alu_data;
    end else if (pop) begin
      write_d   = 1'b1;
      wr_addr_d = fifo_addr_q[rd_ptr_q];
      wr_data_d = fifo_data_q[rd_ptr_q];
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop
  // samples its pre-edge value, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q  <= 2'd0;
      rd_ptr_q  <= 2'd0;
      count_q   <= 3'd0;
      starv_q   <= 3'd0;
      write_q   <= 1'b0;
      wr_addr_q <= 5'd0;
      wr_data_q <= 64'd0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      starv_q   <= starv_d;
      write_q   <= write_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  // NOTE: the FIFO array is deliberately not reset; clearing the pointers
  // and count discards its contents and keeps the storage a plain RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= mem_addr;
      fifo_data_q[wr_ptr_q] <= mem_data;
    end
  end

  assign write      = write_q;
  assign wrAddr     = wr_addr_q;
  assign wrData     = wr_data_q;
  assign fifo_count = count_q;

`ifdef WB_FORWARD_EN
  // Register 31 is never forwarded; its read value always comes from the file.
  assign rdDataA = (write_q && (wr_addr_q == rdAddrA) && (rdAddrA != 5'd31)) ? wr_data_q : rfDataA;
  assign rdDataB = (write_q && (wr_addr_q == rdAddrB) && (rdAddrB != 5'd31)) ? wr_data_q : rfDataB;
`else
  assign rdDataA = rfDataA;
  assign rdDataB = rfDataB;
  logic unused_rd_addr;
  assign unused_rd_addr = ^{rdAddrA, rdAddrB};
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// ---------------------------------------------------------------------------
// tb_writeback_stage
//
// Directed stimulus for writeback_stage. Each stimulus step pushes the
// register-file write it should produce into a scoreboard queue; a separate
// monitor pops and compares on every cycle the DUT asserts write. Status
// outputs (ready flags, fifo_count, bypass data) are checked in-line.
// ---------------------------------------------------------------------------
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid, alu_ready;
  logic [4:0]  alu_addr;
  logic [63:0] alu_data;
  logic        mem_valid, mem_ready;
  logic [4:0]  mem_addr;
  logic [63:0] mem_data;
  logic        write;
  logic [4:0]  wrAddr;
  logic [63:0] wrData;
  logic [4:0]  rdAddrA, rdAddrB;
  logic [63:0] rfDataA, rfDataB;
  logic [63:0] rdDataA, rdDataB;
  logic [2:0]  fifo_count;

  typedef struct packed {
    logic [4:0]  addr;
    logic [63:0] data;
  } wr_t;

  wr_t sb[$];
  int  n_checks = 0;
  int  n_fail   = 0;

  writeback_stage dut (
    .clk        (clk),
    .reset      (reset),
    .alu_valid  (alu_valid),
    .alu_ready  (alu_ready),
    .alu_addr   (alu_addr),
    .alu_data   (alu_data),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .write      (write),
    .wrAddr     (wrAddr),
    .wrData     (wrData),
    .rdAddrA    (rdAddrA),
    .rdAddrB    (rdAddrB),
    .rfDataA    (rfDataA),
    .rfDataB    (rfDataB),
    .rdDataA    (rdDataA),
    .rdDataB    (rdDataB),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_wr(input logic [4:0] addr, input logic [63:0] data);
    sb.push_back('{addr: addr, data: data});
  endtask

  // Monitor: every asserted write must match the oldest expected write.
  initial begin
    wr_t e;
    forever begin
      @(posedge clk);
      #2;
      if (write === 1'b1) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL wr_unexpected: got write to %0d data %h, expected no write", wrAddr, wrData);
        end else begin
          e = sb.pop_front();
          check("wr_addr", {59'd0, wrAddr}, {59'd0, e.addr});
          check("wr_data", wrData, e.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int k;
    reset = 1'b1;
    alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
    mem_valid = 1'b0; mem_addr = '0; mem_data = '0;
    rdAddrA = '0; rdAddrB = '0; rfDataA = '0; rfDataB = '0;

    // Reset state
    repeat (2) cyc();
    reset = 1'b0;
    check("rst_write", {63'd0, write}, 64'd0);
    check("rst_wraddr", {59'd0, wrAddr}, 64'd0);
    check("rst_wrdata", wrData, 64'd0);
    check("rst_count", {61'd0, fifo_count}, 64'd0);
    check("rst_alu_ready", {63'd0, alu_ready}, 64'd1);
    check("rst_mem_ready", {63'd0, mem_ready}, 64'd1);

    // Single ALU write, visible for exactly one cycle
    alu_valid = 1'b1; alu_addr = 5'd5; alu_data = 64'h1111;
    expect_wr(5'd5, 64'h1111);
    cyc();
    alu_valid = 1'b0;
    check("alu_write_now", {63'd0, write}, 64'd1);
    cyc();
    check("alu_write_gone", {63'd0, write}, 64'd0);

    // FIFO fill while the ALU keeps the port busy; 5th load refused
    for (int i = 1; i <= 5; i++) begin
      alu_valid = 1'b1; alu_addr = 5'd10; alu_data = 64'hA000 + 64'(i);
      expect_wr(5'd10, 64'hA000 + 64'(i));
      mem_valid = 1'b1; mem_addr = 5'(i); mem_data = 64'h100 + 64'(i);
      if (i == 5) begin
        check("full_mem_ready", {63'd0, mem_ready}, 64'd0);
        check("full_count", {61'd0, fifo_count}, 64'd4);
      end else begin
        check("fill_mem_ready", {63'd0, mem_ready}, 64'd1);
      end
      cyc();
    end
    alu_valid = 1'b0; mem_valid = 1'b0;
    check("full_hold_count", {61'd0, fifo_count}, 64'd4);
    for (int j = 1; j <= 4; j++) expect_wr(5'(j), 64'h100 + 64'(j));
    repeat (4) cyc();
    check("drain_count", {61'd0, fifo_count}, 64'd0);

    // Starvation: two loads waiting, ALU continuously valid
    k = 0;
    for (int i = 1; i <= 11; i++) begin
      mem_valid = (i <= 2);
      mem_addr  = 5'(20 + i);
      mem_data  = 64'hC000 + 64'(i);
      if (i <= 10) begin
        alu_valid = 1'b1; alu_addr = 5'd11; alu_data = 64'hB000 + 64'(k);
        if (i == 9) begin
          check("starve_alu_ready", {63'd0, alu_ready}, 64'd0);
          expect_wr(5'd21, 64'hC001);
        end else begin
          check("alu_ready_high", {63'd0, alu_ready}, 64'd1);
          expect_wr(5'd11, 64'hB000 + 64'(k));
          k++;
        end
        if (i == 10) check("starve_count", {61'd0, fifo_count}, 64'd1);
      end else begin
        alu_valid = 1'b0;
        expect_wr(5'd22, 64'hC002);
      end
      cyc();
    end
    check("starve_drain", {61'd0, fifo_count}, 64'd0);

    // Back-to-back loads: push and pop together, pointers wrap
    for (int i = 1; i <= 6; i++) begin
      mem_valid = 1'b1; mem_addr = 5'(i); mem_data = 64'hD000 + 64'(i);
      expect_wr(5'(i), 64'hD000 + 64'(i));
      if (i >= 2) check("pushpop_count", {61'd0, fifo_count}, 64'd1);
      cyc();
    end
    mem_valid = 1'b0;
    cyc();
    check("wrap_count", {61'd0, fifo_count}, 64'd0);

    // Reset with three loads buffered; nothing stale may come out
    for (int i = 1; i <= 3; i++) begin
      alu_valid = 1'b1; alu_addr = 5'd12; alu_data = 64'hE000 + 64'(i);
      expect_wr(5'd12, 64'hE000 + 64'(i));
      mem_valid = 1'b1; mem_addr = 5'(25 + i); mem_data = 64'hF000 + 64'(i);
      cyc();
    end
    check("pre_reset_count", {61'd0, fifo_count}, 64'd3);
    reset = 1'b1; alu_valid = 1'b0; mem_valid = 1'b0;
    cyc();
    check("mid_reset_write", {63'd0, write}, 64'd0);
    check("mid_reset_count", {61'd0, fifo_count}, 64'd0);
    reset = 1'b0;
    check("post_reset_alu_ready", {63'd0, alu_ready}, 64'd1);
    check("post_reset_mem_ready", {63'd0, mem_ready}, 64'd1);
    repeat (6) cyc();
    check("post_reset_idle_count", {61'd0, fifo_count}, 64'd0);

    // Read bus bypass
    rfDataA = 64'h5555; rfDataB = 64'h6666;
    rdAddrA = 5'd7; rdAddrB = 5'd7;
    alu_valid = 1'b1; alu_addr = 5'd7; alu_data = 64'hABCD;
    expect_wr(5'd7, 64'hABCD);
    cyc();
    alu_valid = 1'b0;
`ifdef WB_FORWARD_EN
    check("fwd_a_hit", rdDataA, 64'hABCD);
    check("fwd_b_hit", rdDataB, 64'hABCD);
`else
    check("pass_a", rdDataA, 64'h5555);
    check("pass_b", rdDataB, 64'h6666);
`endif
    rdAddrB = 5'd8;
    #1;
    check("fwd_b_miss", rdDataB, 64'h6666);
    cyc();
    rdAddrA = 5'd31;
    alu_valid = 1'b1; alu_addr = 5'd31; alu_data = 64'h77;
    expect_wr(5'd31, 64'h77);
    cyc();
    alu_valid = 1'b0;
    check("fwd_a_r31", rdDataA, 64'h5555);
    cyc();
    check("idle_no_fwd", rdDataA, 64'h5555);

    repeat (3) cyc();
    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/writeback_stage.md
WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 SHALL have a single clock and a synchronous, active-high reset, named clk and reset as in the register file.
REQ-002 SHALL provide port clk  input  1  rising-edge clock.
REQ-003 SHALL provide port reset  input  1  synchronous active-high reset.
REQ-004 SHALL provide ports alu_valid in 1, alu_ready out 1, alu_addr in 5, alu_data in 64: ALU result channel.
REQ-005 SHALL provide ports mem_valid in 1, mem_ready out 1, mem_addr in 5, mem_data in 64: load result channel.
REQ-006 SHALL provide ports write out 1, wrAddr out 5, wrData out 64: register-file write port.
REQ-007 SHALL provide ports rdAddrA in 5, rdAddrB in 5, rfDataA in 64, rfDataB in 64, rdDataA out 64, rdDataB out 64: read-bus pass-through/bypass.
REQ-008 SHALL provide port fifo_count  out  3  number of load results held, 0..4.

Function
REQ-009 SHALL transfer a channel word only in a cycle where valid and ready are both high at the clk edge.
REQ-010 SHALL push each accepted load result into a 4-entry FIFO, in order; it SHALL NOT write load results directly.
REQ-011 SHALL drive mem_ready = (fifo_count != 4); a full FIFO SHALL block loads and cause no overwrite.
REQ-012 SHALL arbitrate the write port once per cycle; the ALU SHALL win if alu_valid && alu_ready, else the FIFO head SHALL pop if fifo_count != 0.
REQ-013 SHALL register the winner: write/wrAddr/wrData SHALL be valid exactly 1 cycle after the ALU handshake, or 1 cycle after the pop.
REQ-014 SHALL make a pushed entry poppable no earlier than the cycle after the push; earliest load write is 2 cycles after its handshake.
REQ-015 SHALL support simultaneous push and pop in one cycle, with fifo_count unchanged.
REQ-016 SHALL hold wrAddr/wrData at their last values and drive write low in cycles with no winner.
REQ-017 SHALL keep a 3-bit starvation counter that increments each cycle the ALU wins while fifo_count != 0, and clears on any pop or when the FIFO is empty.
REQ-018 SHALL deassert alu_ready for exactly one cycle when the counter equals 7 and fifo_count != 0; that cycle SHALL pop the FIFO and clear the counter; alu_ready SHALL otherwise be 1.
REQ-019 SHALL pass FIFO pointers through modulo-4 wrap-around with no lost or duplicated entries.
REQ-020 SHALL wrap fifo_count only within 0..4 and never exceed 4.

Reset
REQ-021 SHALL on reset set write=0, wrAddr=0, wrData=0, fifo_count=0, starvation counter=0, and pointers=0.
REQ-022 SHALL discard FIFO contents on reset mid-operation; no write SHALL be issued in the cycle after reset is sampled.
REQ-023 SHALL drive alu_ready=1 and mem_ready=1 in the first cycle after reset is released.

Configuration
REQ-024 SHALL use macro WB_FORWARD_EN to compile the write bypass in or out.
REQ-025 SHALL, with WB_FORWARD_EN defined, drive rdDataA = wrData when write && wrAddr == rdAddrA && rdAddrA != 31, else rfDataA; rdDataB SHALL be the same using rdAddrB and rfDataB.
REQ-026 SHALL, without WB_FORWARD_EN, drive rdDataA = rfDataA and rdDataB = rfDataB combinationally, with no added logic.

Verification
REQ-027 SHALL pass: ALU handshake addr 5, data 64'h1111 in cycle N -> write=1, wrAddr=5, wrData=64'h1111 in cycle N+1 only.
REQ-028 SHALL pass: loads to addr 1,2,3,4,5 on consecutive cycles while ALU busy -> 4 accepted, mem_ready=0 on 5th, fifo_count=4.
REQ-029 SHALL pass: ALU valid continuously, FIFO holding 2 entries -> after 7 ALU wins alu_ready=0 for one cycle, the load is written, then the ALU resumes.
REQ-030 SHALL pass: 6 loads pushed and popped in order across pointer wrap -> wrData sequence equals push order, no duplicates.
REQ-031 SHALL pass: reset asserted with fifo_count=3 -> next cycle fifo_count=0, write=0; no stale entries are written afterwards.
REQ-032 SHALL pass: with WB_FORWARD_EN, write to addr 7 data 64'hABCD while rdAddrA=7 -> rdDataA=64'hABCD; with rdAddrA=31 and wrAddr=31 -> rdDataA=rfDataA.
